// File: rtl/eth_hsr_dup_filter_pkg.sv
// Shared types and defaults for the HSR RX duplicate-discard stage.
package eth_hsr_dup_filter_pkg;

  localparam int HSR_DUP_TBL_DEPTH = 64;
  localparam int HSR_DUP_AGE_MS    = 400;
  localparam int HSR_DUP_TS_W      = 10;
  localparam int HSR_DUP_CNT_W     = 8;

  typedef enum logic [2:0] {
    OWN_SRC, NON_HSR, DUP_SAME, DUP_OTHER, MCAST, TO_ARM, TO_PEER
  } filt_reason_t;

  typedef struct packed {
    logic                    valid;
    logic [1:0]              seen;
    logic [HSR_DUP_TS_W-1:0] ts;
    logic [15:0]             seq;
    logic [47:0]             src_mac;
  } hsr_dup_entry_t;

  typedef struct packed {
    logic        port;
    logic        is_hsr;
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [15:0] seq;
  } hsr_req_t;

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DECIDE, ST_RESP} dup_state_t;

  function automatic logic [1:0] port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/eth_hsr_dup_filter_ms.sv
// Millisecond prescaler: single-cycle tick every CLK_FREQ_HZ/1000 clocks.
module eth_ms_tick #(
  parameter int CLK_FREQ_HZ = 125_000_000
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int DIV = (CLK_FREQ_HZ / 1000 > 1) ? CLK_FREQ_HZ / 1000 : 2;
  localparam int W   = $clog2(DIV);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == '0);

  always_comb cnt_d = tick ? W'(DIV - 1) : cnt_q - W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= W'(DIV - 1);
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/eth_hsr_dup_filter.sv
// HSR RX disposition: own-MAC discard, aged duplicate table shared by ports A/B,
// forwarding decision towards ARM and/or the peer port.
module eth_hsr_dup_filter
  import eth_hsr_dup_filter_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 125_000_000,
  parameter int TBL_DEPTH   = HSR_DUP_TBL_DEPTH,
  parameter int AGE_MS      = HSR_DUP_AGE_MS,
  parameter int TS_W        = HSR_DUP_TS_W,
  parameter int CNT_W       = HSR_DUP_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [47:0]      arm_mac,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_port,
  input  logic             req_is_hsr,
  input  logic [47:0]      req_dst_mac,
  input  logic [47:0]      req_src_mac,
  input  logic [15:0]      req_seq,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_fwd_arm,
  output logic             rsp_fwd_peer,
  output filt_reason_t     rsp_reason,
  output logic [CNT_W-1:0] dup_cnt_a,
  output logic [CNT_W-1:0] dup_cnt_b
);
  // state  | meaning
  // IDLE   | wait for descriptor, age-sweep one entry per cycle
  // SCAN   | visit every entry: match, victim search, expiry
  // DECIDE | apply filter rules, update table and counters
  // RESP   | present disposition until rsp_ready

  localparam int IDX_W = $clog2(TBL_DEPTH);
  typedef logic [IDX_W-1:0] idx_t;
  localparam idx_t LAST_IDX = idx_t'(TBL_DEPTH - 1);

  dup_state_t       state_q, state_d;
  hsr_req_t         req_q, req_d;
  hsr_dup_entry_t   tbl_q [TBL_DEPTH];
  hsr_dup_entry_t   tbl_d [TBL_DEPTH];
  hsr_dup_entry_t   cur;
  idx_t             idx_q, idx_d, sweep_q, sweep_d, rr_q, rr_d;
  idx_t             vic_q, vic_d, hit_q, hit_d, ins_idx;
  logic             vic_ok_q, vic_ok_d, hit_ok_q, hit_ok_d;
  logic             ready_en_q;
  logic [TS_W-1:0]  now_ms_q, now_ms_d;
  logic             tick, accept, rsp_fire, cur_exp, cur_match;
  logic             rsp_valid_q, rsp_valid_d, fwd_arm_q, fwd_arm_d, fwd_peer_q, fwd_peer_d;
  filt_reason_t     reason_q, reason_d;
  logic [CNT_W-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;

  function automatic logic is_expired(input logic [TS_W-1:0] now, input logic [TS_W-1:0] ts);
    logic [TS_W-1:0] age;
    age = now - ts;
    return age >= TS_W'(AGE_MS);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  eth_ms_tick #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_ms_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  assign req_ready = (state_q == ST_IDLE) && ready_en_q;
  assign accept    = req_valid && req_ready;
  assign rsp_fire  = rsp_valid_q && rsp_ready;
  // One table read port: SCAN walks for the latched request, IDLE walks the sweep pointer
  assign cur       = tbl_q[(state_q == ST_SCAN) ? idx_q : sweep_q];
  assign cur_exp   = is_expired(now_ms_q, cur.ts);
  assign cur_match = cur.valid && !cur_exp && (cur.src_mac == req_q.src_mac) && (cur.seq == req_q.seq);
  assign ins_idx   = vic_ok_q ? vic_q : rr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      for (int i = 0; i < TBL_DEPTH; i++) tbl_q[i] <= '0;
      idx_q       <= '0;
      sweep_q     <= '0;
      rr_q        <= '0;
      vic_q       <= '0;
      hit_q       <= '0;
      vic_ok_q    <= 1'b0;
      hit_ok_q    <= 1'b0;
      ready_en_q  <= 1'b0;
      now_ms_q    <= '0;
      rsp_valid_q <= 1'b0;
      fwd_arm_q   <= 1'b0;
      fwd_peer_q  <= 1'b0;
      reason_q    <= OWN_SRC;
      cnt_a_q     <= '0;
      cnt_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      tbl_q       <= tbl_d;
      idx_q       <= idx_d;
      sweep_q     <= sweep_d;
      rr_q        <= rr_d;
      vic_q       <= vic_d;
      hit_q       <= hit_d;
      vic_ok_q    <= vic_ok_d;
      hit_ok_q    <= hit_ok_d;
      ready_en_q  <= 1'b1;
      now_ms_q    <= now_ms_d;
      rsp_valid_q <= rsp_valid_d;
      fwd_arm_q   <= fwd_arm_d;
      fwd_peer_q  <= fwd_peer_d;
      reason_q    <= reason_d;
      cnt_a_q     <= cnt_a_d;
      cnt_b_q     <= cnt_b_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_SCAN;
      ST_SCAN:   if (idx_q == LAST_IDX) state_d = ST_DECIDE;
      ST_DECIDE: state_d = ST_RESP;
      ST_RESP:   if (rsp_fire) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_d       = req_q;
    tbl_d       = tbl_q;
    idx_d       = idx_q;
    sweep_d     = sweep_q;
    rr_d        = rr_q;
    vic_d       = vic_q;
    hit_d       = hit_q;
    vic_ok_d    = vic_ok_q;
    hit_ok_d    = hit_ok_q;
    now_ms_d    = now_ms_q + TS_W'(tick);
    rsp_valid_d = 1'b0;
    fwd_arm_d   = fwd_arm_q;
    fwd_peer_d  = fwd_peer_q;
    reason_d    = reason_q;
    cnt_a_d     = cnt_a_q;
    cnt_b_d     = cnt_b_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          req_d    = '{port: req_port, is_hsr: req_is_hsr, dst_mac: req_dst_mac,
                       src_mac: req_src_mac, seq: req_seq};
          idx_d    = '0;
          vic_ok_d = 1'b0;
          hit_ok_d = 1'b0;
        end else begin
          if (cur.valid && cur_exp) tbl_d[sweep_q].valid = 1'b0;
          sweep_d = sweep_q + idx_t'(1);
        end
      end
      ST_SCAN: begin
        if (cur.valid && cur_exp) tbl_d[idx_q].valid = 1'b0;
        if ((!cur.valid || cur_exp) && !vic_ok_q) begin
          vic_d    = idx_q;
          vic_ok_d = 1'b1;
        end
        if (cur_match) begin
          hit_d    = idx_q;
          hit_ok_d = 1'b1;
        end
        idx_d = idx_q + idx_t'(1);
      end
      ST_DECIDE: begin
        fwd_arm_d  = 1'b0;
        fwd_peer_d = 1'b0;
        if (req_q.src_mac == arm_mac) begin
          reason_d = OWN_SRC;
        end else if (!req_q.is_hsr) begin
          reason_d  = NON_HSR;
          fwd_arm_d = 1'b1;
        end else if (hit_ok_q) begin
          if (tbl_q[hit_q].seen[req_q.port]) begin
            reason_d = DUP_SAME;
          end else begin
            reason_d = DUP_OTHER;
            tbl_d[hit_q].seen = tbl_q[hit_q].seen | port_onehot(req_q.port);
          end
          if (req_q.port) cnt_b_d = sat_inc(cnt_b_q);
          else            cnt_a_d = sat_inc(cnt_a_q);
        end else begin
          tbl_d[ins_idx] = '{valid: 1'b1, seen: port_onehot(req_q.port), ts: now_ms_q,
                             seq: req_q.seq, src_mac: req_q.src_mac};
          rr_d = rr_q + idx_t'(1);
          if (req_q.dst_mac[40]) begin
            reason_d   = MCAST;
            fwd_arm_d  = 1'b1;
            fwd_peer_d = 1'b1;
          end else if (req_q.dst_mac == arm_mac) begin
            reason_d  = TO_ARM;
            fwd_arm_d = 1'b1;
          end else begin
            reason_d   = TO_PEER;
            fwd_peer_d = 1'b1;
          end
        end
      end
      ST_RESP: rsp_valid_d = !rsp_fire;
      default: ;
    endcase
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_fwd_arm  = fwd_arm_q;
  assign rsp_fwd_peer = fwd_peer_q;
  assign rsp_reason   = reason_q;
  assign dup_cnt_a    = cnt_a_q;
  assign dup_cnt_b    = cnt_b_q;

endmodule

// File: tb/tb_eth_hsr_dup_filter.sv
// Bench for eth_hsr_dup_filter: directed vector table, stall/reset/fill/wrap/saturation
// sequences, and randomized traffic against a key->seen-ports reference model.
module tb_eth_hsr_dup_filter;
  import eth_hsr_dup_filter_pkg::*;

  localparam int MS_CYC = 16;
  localparam int LAT    = HSR_DUP_TBL_DEPTH + 2;
  localparam logic [47:0] ARM   = 48'h02_00_00_00_00_AA;
  localparam logic [47:0] S1    = 48'h02_00_00_00_00_01;
  localparam logic [47:0] S2    = 48'h02_00_00_00_00_02;
  localparam logic [47:0] S3    = 48'h02_00_00_00_00_03;
  localparam logic [47:0] S4    = 48'h02_00_00_00_00_04;
  localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] UNI   = 48'h02_00_00_00_00_77;
  localparam logic [47:0] MC    = 48'h01_00_5E_00_00_01;

  logic         clk, reset_n, req_valid, req_ready, req_port, req_is_hsr;
  logic [47:0]  arm_mac, req_dst_mac, req_src_mac;
  logic [15:0]  req_seq;
  logic         rsp_valid, rsp_ready, rsp_fwd_arm, rsp_fwd_peer;
  filt_reason_t rsp_reason;
  logic [7:0]   dup_cnt_a, dup_cnt_b;

  int n_tests = 0;
  int n_fail  = 0;

  eth_hsr_dup_filter #(.CLK_FREQ_HZ(MS_CYC * 1000)) dut (
    .clk(clk), .reset_n(reset_n), .arm_mac(arm_mac),
    .req_valid(req_valid), .req_ready(req_ready), .req_port(req_port),
    .req_is_hsr(req_is_hsr), .req_dst_mac(req_dst_mac), .req_src_mac(req_src_mac),
    .req_seq(req_seq), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_fwd_arm(rsp_fwd_arm), .rsp_fwd_peer(rsp_fwd_peer), .rsp_reason(rsp_reason),
    .dup_cnt_a(dup_cnt_a), .dup_cnt_b(dup_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int           pre_ms;
    logic         port;
    logic         hsr;
    logic [47:0]  dst;
    logic [47:0]  src;
    logic [15:0]  seq;
    logic         arm;
    logic         peer;
    filt_reason_t rsn;
  } vec_t;

  vec_t tv [12];
  logic [1:0] seen_m [logic [63:0]];
  logic [47:0] rsrc [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tmo(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n   = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic send_req(input logic port, input logic hsr, input logic [47:0] dst,
                          input logic [47:0] src, input logic [15:0] seq);
    int n;
    @(negedge clk);
    req_port = port; req_is_hsr = hsr; req_dst_mac = dst; req_src_mac = src; req_seq = seq;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) tmo("req_ready");
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic get_rsp(output logic arm, output logic peer, output logic [2:0] rsn, output int lat);
    lat = 0;
    while (!rsp_valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) tmo("rsp_valid");
    arm = rsp_fwd_arm; peer = rsp_fwd_peer; rsn = rsp_reason;
  endtask

  task automatic run_req(input logic port, input logic hsr, input logic [47:0] dst,
                         input logic [47:0] src, input logic [15:0] seq,
                         output logic arm, output logic peer, output logic [2:0] rsn, output int lat);
    send_req(port, hsr, dst, src, seq);
    get_rsp(arm, peer, rsn, lat);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: key {src,seq} -> set of ports already seen; no aging needed
  // because every randomized burst completes well inside one entry lifetime.
  task automatic model(input logic port, input logic hsr, input logic [47:0] dst,
                       input logic [47:0] src, input logic [15:0] seq,
                       output logic [4:0] exp, inout int ea, inout int eb);
    logic [63:0] key;
    logic [1:0]  pm;
    key = {src, seq};
    pm  = port ? 2'b10 : 2'b01;
    if (src == ARM) exp = {2'b00, 3'(OWN_SRC)};
    else if (!hsr) exp = {2'b10, 3'(NON_HSR)};
    else if (seen_m.exists(key)) begin
      if ((seen_m[key] & pm) != 0) exp = {2'b00, 3'(DUP_SAME)};
      else begin
        exp = {2'b00, 3'(DUP_OTHER)};
        seen_m[key] = seen_m[key] | pm;
      end
      if (port) eb++;
      else ea++;
    end else begin
      seen_m[key] = pm;
      if (dst[40]) exp = {2'b11, 3'(MCAST)};
      else if (dst == ARM) exp = {2'b10, 3'(TO_ARM)};
      else exp = {2'b01, 3'(TO_PEER)};
    end
  endtask

  initial begin
    logic       a, p, sa, sp;
    logic [2:0] r, sr;
    logic [4:0] e;
    int         lat, bad, ea, eb;

    reset_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1; arm_mac = ARM;
    req_port = 1'b0; req_is_hsr = 1'b0; req_dst_mac = '0; req_src_mac = '0; req_seq = '0;
    rsrc = '{S1, S2, S3, S4};

    tv[0]  = '{0,   1'b0, 1'b1, BCAST, S1,  16'd5, 1'b1, 1'b1, MCAST};
    tv[1]  = '{10,  1'b1, 1'b1, BCAST, S1,  16'd5, 1'b0, 1'b0, DUP_OTHER};
    tv[2]  = '{0,   1'b0, 1'b1, BCAST, S1,  16'd5, 1'b0, 1'b0, DUP_SAME};
    tv[3]  = '{410, 1'b0, 1'b1, BCAST, S1,  16'd5, 1'b1, 1'b1, MCAST};
    tv[4]  = '{380, 1'b0, 1'b1, BCAST, S1,  16'd5, 1'b0, 1'b0, DUP_SAME};
    tv[5]  = '{0,   1'b0, 1'b1, BCAST, ARM, 16'd9, 1'b0, 1'b0, OWN_SRC};
    tv[6]  = '{0,   1'b1, 1'b0, BCAST, ARM, 16'd9, 1'b0, 1'b0, OWN_SRC};
    tv[7]  = '{0,   1'b0, 1'b0, UNI,   S2,  16'd0, 1'b1, 1'b0, NON_HSR};
    tv[8]  = '{0,   1'b0, 1'b1, ARM,   S2,  16'd1, 1'b1, 1'b0, TO_ARM};
    tv[9]  = '{0,   1'b1, 1'b1, UNI,   S2,  16'd2, 1'b0, 1'b1, TO_PEER};
    tv[10] = '{0,   1'b0, 1'b1, UNI,   S2,  16'd2, 1'b0, 1'b0, DUP_OTHER};
    tv[11] = '{0,   1'b1, 1'b1, MC,    S2,  16'd3, 1'b1, 1'b1, MCAST};

    repeat (2) @(negedge clk);
    chk("reset req_ready", req_ready, 0);
    chk("reset rsp", {rsp_valid, rsp_fwd_arm, rsp_fwd_peer, 3'(rsp_reason)}, 0);
    chk("reset counters", {dup_cnt_a, dup_cnt_b}, 0);
    reset_n = 1'b1;
    chk("req_ready before first clock", req_ready, 0);
    @(negedge clk);
    chk("req_ready after first clock", req_ready, 1);

    for (int i = 0; i < 12; i++) begin
      repeat (tv[i].pre_ms * MS_CYC) @(posedge clk);
      run_req(tv[i].port, tv[i].hsr, tv[i].dst, tv[i].src, tv[i].seq, a, p, r, lat);
      chk($sformatf("vec%0d rsp", i), {a, p, r}, {tv[i].arm, tv[i].peer, 3'(tv[i].rsn)});
      chk($sformatf("vec%0d latency", i), 64'(lat), 64'(LAT));
    end
    chk("vec dup_cnt_a", dup_cnt_a, 3);
    chk("vec dup_cnt_b", dup_cnt_b, 1);

    rsp_ready = 1'b0;
    send_req(1'b0, 1'b1, UNI, S4, 16'd1);
    get_rsp(sa, sp, sr, lat);
    chk("stall rsp", {sa, sp, sr}, {2'b01, 3'(TO_PEER)});
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!rsp_valid || req_ready || rsp_fwd_arm != sa || rsp_fwd_peer != sp || rsp_reason != sr) bad++;
    end
    chk("stall hold cycles bad", 64'(bad), 0);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rsp_valid after handshake", rsp_valid, 0);

    send_req(1'b0, 1'b1, UNI, S2, 16'd2);
    repeat (20) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mid-scan reset rsp_valid/req_ready", {rsp_valid, req_ready}, 0);
    chk("mid-scan reset counters", {dup_cnt_a, dup_cnt_b}, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    run_req(1'b0, 1'b1, UNI, S2, 16'd2, a, p, r, lat);
    chk("after reset frame is new", {a, p, r}, {2'b01, 3'(TO_PEER)});
    chk("after reset latency", 64'(lat), 64'(LAT));

    apply_reset();
    seen_m.delete();
    ea = 0; eb = 0; bad = 0;
    for (int i = 0; i < 60; i++) begin
      logic        rp, rh;
      logic [47:0] rs, rd;
      logic [15:0] rq;
      int          ds;
      rs = ($urandom_range(0, 7) == 0) ? ARM : rsrc[$urandom_range(0, 3)];
      rq = 16'($urandom_range(0, 7));
      rp = 1'($urandom_range(0, 1));
      rh = ($urandom_range(0, 9) != 0);
      ds = $urandom_range(0, 3);
      rd = (ds == 0) ? BCAST : (ds == 1) ? ARM : (ds == 2) ? UNI : MC;
      model(rp, rh, rd, rs, rq, e, ea, eb);
      run_req(rp, rh, rd, rs, rq, a, p, r, lat);
      chk($sformatf("rand%0d rsp", i), {a, p, r}, e);
    end
    chk("rand dup_cnt_a", dup_cnt_a, 64'(ea));
    chk("rand dup_cnt_b", dup_cnt_b, 64'(eb));

    apply_reset();
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      run_req(1'b0, 1'b1, BCAST, S3, 16'(100 + i), a, p, r, lat);
      if ({a, p, r} != {2'b11, 3'(MCAST)}) bad++;
    end
    chk("fill inserts not MCAST", 64'(bad), 0);
    run_req(1'b0, 1'b1, BCAST, S3, 16'd200, a, p, r, lat);
    chk("65th insert", {a, p, r}, {2'b11, 3'(MCAST)});
    run_req(1'b0, 1'b1, BCAST, S3, 16'd100, a, p, r, lat);
    chk("evicted victim resend", {a, p, r}, {2'b11, 3'(MCAST)});
    run_req(1'b0, 1'b1, BCAST, S3, 16'd102, a, p, r, lat);
    chk("surviving entry resend", {a, p, r}, {2'b00, 3'(DUP_SAME)});

    apply_reset();
    run_req(1'b1, 1'b1, BCAST, S4, 16'd7, a, p, r, lat);
    chk("wrap first insert", {a, p, r}, {2'b11, 3'(MCAST)});
    repeat (1100 * MS_CYC) @(posedge clk);
    run_req(1'b1, 1'b1, BCAST, S4, 16'd7, a, p, r, lat);
    chk("resend after 1100 ms", {a, p, r}, {2'b11, 3'(MCAST)});

    apply_reset();
    for (int k = 0; k < 4; k++) begin
      run_req(1'b0, 1'b1, BCAST, S1, 16'(k), a, p, r, lat);
      for (int j = 0; j < 70; j++) run_req(1'b1, 1'b1, BCAST, S1, 16'(k), a, p, r, lat);
      if (k == 2) chk("dup_cnt_b before saturation", dup_cnt_b, 210);
    end
    chk("dup_cnt_b saturated", dup_cnt_b, 255);
    chk("dup_cnt_a untouched", dup_cnt_a, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
